// File: rtl/seg7_msg_driver_pkg.sv
// Shared types, character codes, scroll message and segment table for the
// 4-digit 7-segment message driver.
package seg7_pkg;

   typedef logic [4:0] char_t;

   typedef enum logic {
      ST_RESULT,
      ST_SCROLL
   } state_t;

   localparam char_t CH_0     = 5'h00;
   localparam char_t CH_1     = 5'h01;
   localparam char_t CH_2     = 5'h02;
   localparam char_t CH_3     = 5'h03;
   localparam char_t CH_4     = 5'h04;
   localparam char_t CH_5     = 5'h05;
   localparam char_t CH_6     = 5'h06;
   localparam char_t CH_7     = 5'h07;
   localparam char_t CH_8     = 5'h08;
   localparam char_t CH_9     = 5'h09;
   localparam char_t CH_A     = 5'h0A;
   localparam char_t CH_B     = 5'h0B;
   localparam char_t CH_C     = 5'h0C;
   localparam char_t CH_D     = 5'h0D;
   localparam char_t CH_E     = 5'h0E;
   localparam char_t CH_F     = 5'h0F;
   localparam char_t CH_H     = 5'h10;
   localparam char_t CH_L     = 5'h11;
   localparam char_t CH_M     = 5'h12;
   localparam char_t CH_U     = 5'h13;
   localparam char_t CH_N     = 5'h14;
   localparam char_t CH_BLANK = 5'h15;
   localparam char_t CH_DASH  = 5'h16;

   localparam int unsigned MSG_LEN  = 18;
   localparam int unsigned LAST_PTR = MSG_LEN - 4;

   // Four blanks each side so the text slides in from the right and out to the left
   localparam char_t MSG_BUF [MSG_LEN] = '{
      CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK,
      CH_H, CH_0, CH_L, CH_A, CH_BLANK, CH_M, CH_U, CH_N, CH_D, CH_0,
      CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK
   };

   // Segment order {g,f,e,d,c,b,a}, active high
   function automatic logic [6:0] seg_of(input char_t c);
      logic [6:0] s;
      case (c)
         CH_0:     s = 7'h3F;
         CH_1:     s = 7'h06;
         CH_2:     s = 7'h5B;
         CH_3:     s = 7'h4F;
         CH_4:     s = 7'h66;
         CH_5:     s = 7'h6D;
         CH_6:     s = 7'h7D;
         CH_7:     s = 7'h07;
         CH_8:     s = 7'h7F;
         CH_9:     s = 7'h6F;
         CH_A:     s = 7'h77;
         CH_B:     s = 7'h7C;
         CH_C:     s = 7'h39;
         CH_D:     s = 7'h5E;
         CH_E:     s = 7'h79;
         CH_F:     s = 7'h71;
         CH_H:     s = 7'h76;
         CH_L:     s = 7'h38;
         CH_M:     s = 7'h2B; // no true M on 7 segments; approximation distinct from N
         CH_U:     s = 7'h3E;
         CH_N:     s = 7'h37;
         CH_DASH:  s = 7'h40;
         default:  s = 7'h00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_msg_driver_if.sv
// Board-side signal bundle for the 7-segment message driver.
interface seg7_msg_driver_if;
   logic       op;
   logic [3:0] sum;
   logic       cout;
   logic       start;
   logic [6:0] seg;
   logic [3:0] an;
   logic       busy;
   logic       done;

   modport master (
      output op, sum, cout, start,
      input  seg, an, busy, done
   );

   modport slave (
      input  op, sum, cout, start,
      output seg, an, busy, done
   );
endinterface

// File: rtl/seg7_msg_driver_char_enc.sv
// Combinational character-code to segment-pattern encoder.
module seg7_char_enc
   import seg7_pkg::*;
(
   input  char_t      i_char,
   output logic [6:0] o_seg
);

   assign o_seg = seg_of(i_char);

endmodule

// File: rtl/seg7_msg_driver.sv
// Multiplexed 4-digit display driver: live adder result or scrolling "HOLA MUNDO".
// Build option: define LEAD_ZERO_BLANK_EN to blank the carry digit when cout=0.
module seg7_msg_driver
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned STEP_DIV    = 100
)(
   input  logic              clk,
   input  logic              rst_n,
   seg7_msg_driver_if.slave  bus
);

   localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned FW = $clog2(STEP_DIV + 1);

   logic [RW-1:0] r_ref;
   logic [1:0]    r_dig;
   logic          r_op;
   logic [3:0]    r_sum;
   logic          r_cout;
   state_t        r_state;
   logic [3:0]    r_ptr;
   logic [FW-1:0] r_frame;
   logic          r_busy;
   logic          r_done;
   logic [6:0]    r_seg;
   logic [3:0]    r_an;

   logic          w_wrap;
   logic          w_frame_end;
   logic          w_step;
   logic [4:0]    w_buf_idx;
   char_t         w_char;
   logic [6:0]    w_seg;

   assign w_wrap      = (r_ref == RW'(REFRESH_DIV - 1));
   assign w_frame_end = w_wrap && (r_dig == 2'd3);
   assign w_step      = w_frame_end && (r_frame == FW'(STEP_DIV - 1));
   assign w_buf_idx   = 5'(r_ptr) + 5'd3 - 5'(r_dig);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= 1'b0;
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else begin
         r_op   <= bus.op;
         r_sum  <= bus.sum;
         r_cout <= bus.cout;
      end
   end

   // r_dig names the digit loaded at the next wrap; an/seg load together from it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ref <= '0;
         r_dig <= '0;
         r_an  <= '1;
         r_seg <= '0;
      end else if (w_wrap) begin
         r_ref <= '0;
         r_dig <= r_dig + 2'd1;
         r_an  <= ~(4'b0001 << r_dig);
         r_seg <= w_seg;
      end else begin
         r_ref <= r_ref + 1'b1;
      end
   end

   always_comb begin
      w_char = CH_BLANK;
      if (r_state == ST_SCROLL) begin
         w_char = MSG_BUF[w_buf_idx];
      end else begin
         case (r_dig)
            2'd0: w_char = char_t'({1'b0, r_sum});
`ifdef LEAD_ZERO_BLANK_EN
            2'd1: w_char = r_cout ? CH_1 : CH_BLANK;
`else
            2'd1: w_char = r_cout ? CH_1 : CH_0;
`endif
            2'd2: w_char = CH_BLANK;
            default: w_char = r_op ? CH_5 : CH_A;
         endcase
      end
   end

   seg7_char_enc u_enc (
      .i_char (w_char),
      .o_seg  (w_seg)
   );

   // A start arriving while done is high is dropped: the scroll is treated as still busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RESULT;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ptr   <= '0;
         r_frame <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_RESULT: begin
               if (bus.start && !r_done) begin
                  r_state <= ST_SCROLL;
                  r_busy  <= 1'b1;
                  r_ptr   <= '0;
                  r_frame <= '0;
               end
            end
            ST_SCROLL: begin
               if (w_step) begin
                  r_frame <= '0;
                  if (r_ptr == 4'(LAST_PTR)) begin
                     r_state <= ST_RESULT;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_ptr <= r_ptr + 4'd1;
                  end
               end else if (w_frame_end) begin
                  r_frame <= r_frame + 1'b1;
               end
            end
            default: r_state <= ST_RESULT;
         endcase
      end
   end

   assign bus.seg  = r_seg;
   assign bus.an   = r_an;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

// File: tb/tb_seg7_msg_driver.sv
// Directed bench for seg7_msg_driver with REFRESH_DIV=4, STEP_DIV=2.
module tb_seg7_msg_driver;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   cyc;

   seg7_msg_driver_if bus ();

   seg7_msg_driver #(
      .REFRESH_DIV (4),
      .STEP_DIV    (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

`ifdef LEAD_ZERO_BLANK_EN
   localparam logic [6:0] EXP_D1_ZERO = 7'h00;
`else
   localparam logic [6:0] EXP_D1_ZERO = 7'h3F;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_slot(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
      chk({tag, "_an"}, 32'(bus.an), 32'(an_exp));
      chk({tag, "_seg"}, 32'(bus.seg), 32'(seg_exp));
   endtask

   initial begin
      int first;
      int s_cyc;
      int rel;
      int done_at;
      int n_done;

      n_vec = 0;
      n_err = 0;
      rst_n = 1'b1;
      bus.op = 1'b0;
      bus.sum = 4'd4;
      bus.cout = 1'b1;
      bus.start = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      chk_slot("rst", 4'b1111, 7'h00);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      step(2);
      chk_slot("rst_hold", 4'b1111, 7'h00);
      @(negedge clk) rst_n = 1'b1;

      first = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (bus.an != 4'b1111) begin
            first = i;
            break;
         end
      end
      chk("first_an_cycles", 32'(first), 4);
      chk_slot("add_d0", 4'b1110, 7'h66);
      step(4); chk_slot("add_d1", 4'b1101, 7'h06);
      step(4); chk_slot("add_d2", 4'b1011, 7'h00);
      step(4); chk_slot("add_d3", 4'b0111, 7'h77);

      bus.op = 1'b1;
      step(16); chk_slot("sub_d3", 4'b0111, 7'h6D);

      bus.sum = 4'd7;
      bus.cout = 1'b0;
      step(4); chk_slot("s7_d0", 4'b1110, 7'h07);
      step(4); chk_slot("s7_d1", 4'b1101, EXP_D1_ZERO);
      step(4); chk_slot("s7_d2", 4'b1011, 7'h00);
      step(4); chk_slot("s7_d3", 4'b0111, 7'h6D);

      // start sampled exactly on a frame-end edge
      repeat (15) @(posedge clk);
      @(negedge clk) bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      s_cyc = cyc;
      chk("busy_rise", 32'(bus.busy), 1);
      chk("done_low", 32'(bus.done), 0);

      step(4);   chk_slot("p0_d0", 4'b1110, 7'h00);
      step(32);  chk_slot("p1_d0", 4'b1110, 7'h76);
      step(96);  chk_slot("p4_d0", 4'b1110, 7'h77);
      step(4);   chk_slot("p4_d1", 4'b1101, 7'h38);
      step(4);   chk_slot("p4_d2", 4'b1011, 7'h3F);
      step(4);   chk_slot("p4_d3", 4'b0111, 7'h76);

      done_at = -1;
      n_done = 0;
      rel = cyc - s_cyc;
      while (rel < 600) begin
         bus.start = (rel == 200) || (done_at >= 0 && rel == done_at);
         step(1);
         rel = cyc - s_cyc;
         if (bus.done) begin
            n_done = n_done + 1;
            if (done_at < 0) begin
               done_at = rel;
               chk("busy_at_done", 32'(bus.busy), 0);
            end
         end
         if (done_at >= 0 && (rel == done_at + 1 || rel == done_at + 2))
            chk("start_in_done_ignored", 32'(bus.busy), 0);
         if (rel == 484) chk_slot("post_scroll_d0", 4'b1110, 7'h07);
      end
      bus.start = 1'b0;
      chk("done_cycle", 32'(done_at), 480);
      chk("done_count", 32'(n_done), 1);

      @(negedge clk) bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk("busy2", 32'(bus.busy), 1);
      step(100);
      #3 rst_n = 1'b0;
      #1;
      chk_slot("mid_rst", 4'b1111, 7'h00);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_done", 32'(bus.done), 0);
      step(2);
      chk_slot("mid_rst_hold", 4'b1111, 7'h00);
      @(negedge clk) rst_n = 1'b1;

      n_done = 0;
      for (int r = 1; r <= 600; r++) begin
         step(1);
         if (bus.done) n_done = n_done + 1;
         if (r == 4) chk_slot("after_rst_d0", 4'b1110, 7'h07);
      end
      chk("abort_done_count", 32'(n_done), 0);
      chk("abort_busy", 32'(bus.busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
